// File: rtl/mr_csr_pkg.sv
// rtl/mr_csr_pkg.sv - shared constants and types for the machine-mode CSR responder
package mr_csr_pkg;

    localparam int XLEN   = 32;
    localparam int CSRLEN = 12;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef logic [0:0] e_csr_state;
    localparam e_csr_state CSR_IDLE = 1'b0;
    localparam e_csr_state CSR_RESP = 1'b1;

    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [31:0] mask);
        return (old_val & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/mr_csr_counter64.sv
// rtl/mr_csr_counter64.sv - 64-bit event counter with 32-bit half writes
module mr_csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // A half write freezes the whole counter for that edge; the other half holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 64'd0;
        end else if (wr_lo) begin
            count[31:0] <= wdata;
        end else if (wr_hi) begin
            count[63:32] <= wdata;
        end else begin
            count <= count + {61'd0, inc};
        end
    end

endmodule

// File: rtl/mr_csr.sv
// rtl/mr_csr.sv - machine-mode CSR responder with cycle/instret counters
module mr_csr
    import mr_csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] RESET_MTVEC = 32'd0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_valid,
    input  logic              csr_r,
    input  logic              csr_w,
    input  logic [CSRLEN-1:0] csr_addr,
    input  logic [XLEN-1:0]   csr_data,
    input  logic [XLEN-1:0]   csr_wmask,
    output logic              csr_ready,
    output logic              csr_legal,
    output logic              csr_fence,
    output logic              csr_ret_valid,
    output logic [XLEN-1:0]   csr_ret_data,
    input  logic [2:0]        insts_ret
);

    e_csr_state  state;
    logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval;
    logic [63:0] cycle_cnt, instret_cnt;
    logic [31:0] rdata, wval;
    logic        impl, accept, wr_en;

    // Read data returned regardless of csr_r, so the flag carries no information here.
    logic unused_csr_r;
    assign unused_csr_r = csr_r;

    always_comb begin
        rdata = 32'd0;
        impl  = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:                rdata = mstatus;
            CSR_MISA:                   rdata = MISA_VAL;
            CSR_MIE:                    rdata = mie;
            CSR_MTVEC:                  rdata = mtvec;
            CSR_MSCRATCH:               rdata = mscratch;
            CSR_MEPC:                   rdata = mepc;
            CSR_MCAUSE:                 rdata = mcause;
            CSR_MTVAL:                  rdata = mtval;
            CSR_MIP:                    rdata = 32'd0;
            CSR_MCYCLE, CSR_CYCLE, CSR_TIME:       rdata = cycle_cnt[31:0];
            CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH:    rdata = cycle_cnt[63:32];
            CSR_MINSTRET, CSR_INSTRET:             rdata = instret_cnt[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:           rdata = instret_cnt[63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = 32'd0;
            CSR_MHARTID:                rdata = HART_ID;
            default:                    impl  = 1'b0;
        endcase
    end

    assign csr_legal = impl & ~(csr_w & (csr_addr[11:10] == 2'b11));
    assign csr_ready = (state == CSR_IDLE) & ~rst;
    assign csr_fence = 1'b0;
    assign accept    = csr_valid & csr_ready & csr_legal;
    assign wr_en     = accept & csr_w;
    assign wval      = csr_merge(rdata, csr_data, csr_wmask);

    assign csr_ret_valid = (state == CSR_RESP) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CSR_IDLE;
            csr_ret_data <= 32'd0;
        end else if (state == CSR_IDLE) begin
            if (accept) begin
                state        <= CSR_RESP;
                csr_ret_data <= rdata;
            end
        end else begin
            state <= CSR_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus  <= 32'd0;
            mie      <= 32'd0;
            mtvec    <= RESET_MTVEC & ~32'h3;
            mscratch <= 32'd0;
            mepc     <= 32'd0;
            mcause   <= 32'd0;
            mtval    <= 32'd0;
        end else if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS:  mstatus  <= wval & MSTATUS_WMASK;
                CSR_MIE:      mie      <= wval & MIE_WMASK;
                CSR_MTVEC:    mtvec    <= wval & ~32'h3;
                CSR_MSCRATCH: mscratch <= wval;
                CSR_MEPC:     mepc     <= wval & ~32'h1;
                CSR_MCAUSE:   mcause   <= wval;
                CSR_MTVAL:    mtval    <= wval;
                default: ;
            endcase
        end
    end

    mr_csr_counter64 u_cycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (3'd1),
        .wr_lo (wr_en & (csr_addr == CSR_MCYCLE)),
        .wr_hi (wr_en & (csr_addr == CSR_MCYCLEH)),
        .wdata (wval),
        .count (cycle_cnt)
    );

    mr_csr_counter64 u_instret (
        .clk   (clk),
        .rst   (rst),
        .inc   (insts_ret),
        .wr_lo (wr_en & (csr_addr == CSR_MINSTRET)),
        .wr_hi (wr_en & (csr_addr == CSR_MINSTRETH)),
        .wdata (wval),
        .count (instret_cnt)
    );

endmodule

// File: tb/tb_mr_csr.sv
// tb/tb_mr_csr.sv - scoreboard bench for mr_csr
module tb_mr_csr;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid, csr_r, csr_w;
    logic [11:0] csr_addr;
    logic [31:0] csr_data, csr_wmask;
    logic        csr_ready, csr_legal, csr_fence, csr_ret_valid;
    logic [31:0] csr_ret_data;
    logic [2:0]  insts_ret;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] sb[$];  // {check_enable, expected_data}

    always #5 clk = ~clk;

    mr_csr #(.HART_ID(32'd3), .RESET_MTVEC(32'h0000_1003)) dut (
        .clk           (clk),
        .rst           (rst),
        .csr_valid     (csr_valid),
        .csr_r         (csr_r),
        .csr_w         (csr_w),
        .csr_addr      (csr_addr),
        .csr_data      (csr_data),
        .csr_wmask     (csr_wmask),
        .csr_ready     (csr_ready),
        .csr_legal     (csr_legal),
        .csr_fence     (csr_fence),
        .csr_ret_valid (csr_ret_valid),
        .csr_ret_data  (csr_ret_data),
        .insts_ret     (insts_ret)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (csr_ret_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got data %h expected no response", csr_ret_data);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                if (e[32]) chk("resp_data", csr_ret_data, e[31:0]);
            end
        end
    end

    // Issues one legal request at the next falling edge; returns in its response cycle.
    task automatic req(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] m, input logic ck, input logic [31:0] exp);
        @(negedge clk);
        csr_valid = 1'b1; csr_r = ~w; csr_w = w;
        csr_addr = a; csr_data = d; csr_wmask = m;
        #1;
        chk("req_legal", {31'd0, csr_legal}, 32'd1);
        chk("req_ready", {31'd0, csr_ready}, 32'd1);
        sb.push_back({ck, exp});
        @(posedge clk);
        #1;
        csr_valid = 1'b0; csr_w = 1'b0; csr_r = 1'b0;
        @(negedge clk);
        chk("resp_latency", {31'd0, csr_ret_valid}, 32'd1);
        chk("ready_in_resp", {31'd0, csr_ready}, 32'd0);
    endtask

    task automatic illegal(input logic w, input logic [11:0] a);
        @(negedge clk);
        csr_valid = 1'b1; csr_r = 1'b1; csr_w = w;
        csr_addr = a; csr_data = 32'hFFFF_FFFF; csr_wmask = 32'hFFFF_FFFF;
        #1;
        chk("illegal_legal", {31'd0, csr_legal}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("illegal_no_accept", {31'd0, csr_ready}, 32'd1);
        end
        csr_valid = 1'b0; csr_w = 1'b0; csr_r = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got hang expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; csr_valid = 1'b0; csr_r = 1'b0; csr_w = 1'b0;
        csr_addr = 12'd0; csr_data = 32'd0; csr_wmask = 32'd0; insts_ret = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, csr_ready}, 32'd0);
        chk("rst_ret_valid", {31'd0, csr_ret_valid}, 32'd0);
        chk("rst_ret_data", csr_ret_data, 32'd0);
        chk("rst_fence", {31'd0, csr_fence}, 32'd0);
        rst = 1'b0;

        // mscratch write/read and partial mask
        req(1'b1, 12'h340, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 32'd0);
        req(1'b0, 12'h340, 32'd0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        req(1'b1, 12'h340, 32'h1234_5678, 32'h0000_FFFF, 1'b1, 32'hDEAD_BEEF);
        req(1'b0, 12'h340, 32'd0, 32'd0, 1'b1, 32'hDEAD_5678);

        // WARL fields
        req(1'b1, 12'h300, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0);
        req(1'b0, 12'h300, 32'd0, 32'd0, 1'b1, 32'h0000_0088);
        req(1'b1, 12'h304, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0);
        req(1'b0, 12'h304, 32'd0, 32'd0, 1'b1, 32'h0000_0888);
        req(1'b1, 12'h341, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0);
        req(1'b0, 12'h341, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFE);
        req(1'b1, 12'h344, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0);
        req(1'b0, 12'h344, 32'd0, 32'd0, 1'b1, 32'd0);
        req(1'b0, 12'h301, 32'd0, 32'd0, 1'b1, 32'h4000_0100);
        req(1'b0, 12'h305, 32'd0, 32'd0, 1'b1, 32'h0000_1000);
        req(1'b0, 12'hF11, 32'd0, 32'd0, 1'b1, 32'd0);

        // illegal requests
        illegal(1'b1, 12'hF14);
        illegal(1'b0, 12'h7C0);
        illegal(1'b1, 12'hC00);
        req(1'b0, 12'hF14, 32'd0, 32'd0, 1'b1, 32'd3);

        // mcycle carry into mcycleh, then write-suppresses-increment
        req(1'b1, 12'hB80, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'd0);
        req(1'b1, 12'hB00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
        req(1'b0, 12'hC80, 32'd0, 32'd0, 1'b1, 32'd1);
        req(1'b1, 12'hB00, 32'd100, 32'hFFFF_FFFF, 1'b0, 32'd0);
        req(1'b0, 12'hB00, 32'd0, 32'd0, 1'b1, 32'd101);
        req(1'b0, 12'hC00, 32'd0, 32'd0, 1'b1, 32'd103);

        // minstret accumulation and write priority
        @(negedge clk);
        insts_ret = 3'd2;
        repeat (10) @(negedge clk);
        insts_ret = 3'd0;
        req(1'b0, 12'hB02, 32'd0, 32'd0, 1'b1, 32'd20);
        req(1'b0, 12'hB82, 32'd0, 32'd0, 1'b1, 32'd0);
        insts_ret = 3'd2;
        req(1'b1, 12'hB02, 32'd5, 32'hFFFF_FFFF, 1'b0, 32'd0);
        insts_ret = 3'd0;
        req(1'b0, 12'hC02, 32'd0, 32'd0, 1'b1, 32'd5);

        // back-to-back held request, then reset during the response cycle
        @(negedge clk);
        csr_valid = 1'b1; csr_r = 1'b1; csr_w = 1'b0;
        csr_addr = 12'h340; csr_data = 32'd0; csr_wmask = 32'd0;
        sb.push_back({1'b1, 32'hDEAD_5678});
        #1 chk("b2b_ready0", {31'd0, csr_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_ready1", {31'd0, csr_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready2", {31'd0, csr_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1; csr_valid = 1'b0; csr_r = 1'b0;
        @(negedge clk);
        chk("rst_resp_ready", {31'd0, csr_ready}, 32'd0);
        chk("rst_resp_dropped", {31'd0, csr_ret_valid}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_ready", {31'd0, csr_ready}, 32'd0);
        chk("rst_hold_ret_data", csr_ret_data, 32'd0);
        rst = 1'b0;
        #1 chk("rst_release_ready", {31'd0, csr_ready}, 32'd1);
        req(1'b0, 12'h340, 32'd0, 32'd0, 1'b1, 32'd0);
        req(1'b0, 12'h305, 32'd0, 32'd0, 1'b1, 32'h0000_1000);
        req(1'b0, 12'h300, 32'd0, 32'd0, 1'b1, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
